// File: rtl/fifo_pkg.sv
// Width helpers and elaboration-time parameter legality check for sync_fifo_param.
package fifo_pkg;

    function automatic int PTR_W(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int CNT_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int data_width, input int depth,
                                     input int af_level, input int ae_level);
        return (data_width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0)
            && (af_level >= 1) && (af_level <= depth)
            && (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on contents.
// Write lands at the clock edge; read data follows the address combinationally.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level flags, sticky error flags and optional FWFT output.
// Standard read data appears one cycle after rd_enb; writes to a full FIFO are rejected unless paired with a read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_enb,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      rd_enb,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_empty,
    output logic                      almost_full,
    output logic [CNT_W(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      err_clr
);

    localparam int PW = PTR_W(DEPTH);
    localparam int CW = CNT_W(DEPTH);

    if (!params_ok(DATA_WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
        $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO can still take a write when the head is leaving in the same cycle.
    assign rd_acc = rd_enb && !empty;
    assign wr_acc = wr_enb && (!full || rd_acc);

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk        (clk),
        .wr_en_i    (wr_acc && !rst),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (data_in),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (rd_data)
    );

    always_comb begin
        wr_ptr_d    = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // New errors take priority over a same-cycle clear.
        if (wr_enb && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (rd_enb && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = empty ? '0 : rd_data;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_out_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_out_q <= '0;
            end else if (rd_acc) begin
                data_out_q <= rd_data;
            end
        end

        assign data_out = data_out_q;
    end

endmodule
